// File: rtl/bounce_pkg.sv
// Shared constants for the bounce counter sequence controller: state/phase
// encodings and the reset-time bounds that reproduce the legacy 0..3,15..12 pattern.
package bounce_pkg;

    typedef logic [1:0] state_t;

    // State encodings double as the phase output encodings
    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_UP   = 2'b01;
    localparam state_t ST_DOWN = 2'b10;

    localparam logic [1:0] PHASE_IDLE = 2'b00;
    localparam logic [1:0] PHASE_UP   = 2'b01;
    localparam logic [1:0] PHASE_DOWN = 2'b10;

    localparam int unsigned DEF_UP_START = 0;
    localparam int unsigned DEF_UP_END   = 3;
    localparam int unsigned DEF_DN_START = 15;
    localparam int unsigned DEF_DN_END   = 12;

endpackage

// File: rtl/bounce_datapath.sv
// W-bit counter register with load/increment/decrement/hold controls.
// Load has priority over inc, inc over dec; no control active means hold.
module bounce_datapath #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (inc) begin
            q <= q + W'(1);
        end else if (dec) begin
            q <= q - W'(1);
        end
    end

endmodule

// File: rtl/bounce_seq_ctrl.sv
// Sequence controller for the bounce counter: programmable up/down phases,
// loop counting, and configuration loading over a valid/ready handshake while idle.
module bounce_seq_ctrl
    import bounce_pkg::*;
#(
    parameter int unsigned W            = 4,
    parameter int unsigned LW           = 8,
    parameter int unsigned DEF_UP_START = bounce_pkg::DEF_UP_START,
    parameter int unsigned DEF_UP_END   = bounce_pkg::DEF_UP_END,
    parameter int unsigned DEF_DN_START = bounce_pkg::DEF_DN_START,
    parameter int unsigned DEF_DN_END   = bounce_pkg::DEF_DN_END
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [W-1:0]  cfg_up_start,
    input  logic [W-1:0]  cfg_up_end,
    input  logic [W-1:0]  cfg_dn_start,
    input  logic [W-1:0]  cfg_dn_end,
    input  logic [LW-1:0] cfg_loops,
    input  logic          start,
    input  logic          stop,
    input  logic          step_en,
    output logic [W-1:0]  q,
    output logic [1:0]    phase,
    output logic          busy,
    output logic          loop_done,
    output logic          done,
    output logic [LW-1:0] loop_cnt,
    output logic          cfg_err
);

    state_t        state_q, state_d;
    logic [W-1:0]  up_start_q, up_end_q, dn_start_q, dn_end_q;
    logic [LW-1:0] loops_q;
    logic [LW-1:0] loop_cnt_d;
    logic          loop_done_d, done_d, cfg_err_d, cfg_we;
    logic          dp_load, dp_inc, dp_dec;
    logic [W-1:0]  dp_val;
    logic          cfg_ok;

    assign cfg_ready = (state_q == ST_IDLE) && !start;
    assign cfg_ok    = (cfg_up_start <= cfg_up_end) && (cfg_dn_start >= cfg_dn_end);
    assign phase     = state_q;

    bounce_datapath #(.W(W)) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load     (dp_load),
        .load_val (dp_val),
        .inc      (dp_inc),
        .dec      (dp_dec),
        .q        (q)
    );

    // Next-state, datapath controls and pulse generation
    always_comb begin
        state_d     = state_q;
        dp_load     = 1'b0;
        dp_val      = up_start_q;
        dp_inc      = 1'b0;
        dp_dec      = 1'b0;
        loop_cnt_d  = loop_cnt;
        loop_done_d = 1'b0;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        cfg_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_UP;
                    dp_load    = 1'b1;
                    dp_val     = up_start_q;
                    loop_cnt_d = '0;
                end else if (cfg_valid) begin
                    cfg_we    = cfg_ok;
                    cfg_err_d = !cfg_ok;
                end
            end
            ST_UP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (step_en) begin
                    if (q < up_end_q) begin
                        dp_inc = 1'b1;
                    end else begin
                        dp_load = 1'b1;
                        dp_val  = dn_start_q;
                        state_d = ST_DOWN;
                    end
                end
            end
            ST_DOWN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (step_en) begin
                    if (q > dn_end_q) begin
                        dp_dec = 1'b1;
                    end else begin
                        loop_cnt_d  = loop_cnt + LW'(1);
                        loop_done_d = 1'b1;
                        // q holds dn_end when a finite run finishes
                        if ((loops_q != '0) && (loop_cnt_d == loops_q)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            dp_load = 1'b1;
                            dp_val  = up_start_q;
                            state_d = ST_UP;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            busy      <= 1'b0;
            loop_cnt  <= '0;
            loop_done <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy      <= (state_d != ST_IDLE);
            loop_cnt  <= loop_cnt_d;
            loop_done <= loop_done_d;
            done      <= done_d;
            cfg_err   <= cfg_err_d;
        end
    end

    // Configuration registers, reset to the legacy pattern with infinite loops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_start_q <= W'(DEF_UP_START);
            up_end_q   <= W'(DEF_UP_END);
            dn_start_q <= W'(DEF_DN_START);
            dn_end_q   <= W'(DEF_DN_END);
            loops_q    <= '0;
        end else if (cfg_we) begin
            up_start_q <= cfg_up_start;
            up_end_q   <= cfg_up_end;
            dn_start_q <= cfg_dn_start;
            dn_end_q   <= cfg_dn_end;
            loops_q    <= cfg_loops;
        end
    end

endmodule

// File: tb/tb_bounce_seq_ctrl.sv
// Self-checking bench for bounce_seq_ctrl: sequence-list reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_bounce_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_up_start = '0, cfg_up_end = '0, cfg_dn_start = '0, cfg_dn_end = '0;
    logic [7:0] cfg_loops = '0;
    logic       start = 1'b0, stop = 1'b0, step_en = 1'b0;
    logic [3:0] q;
    logic [1:0] phase;
    logic       busy, loop_done, done, cfg_err;
    logic [7:0] loop_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    bounce_seq_ctrl dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_up_start(cfg_up_start), .cfg_up_end(cfg_up_end),
        .cfg_dn_start(cfg_dn_start), .cfg_dn_end(cfg_dn_end),
        .cfg_loops(cfg_loops), .start(start), .stop(stop), .step_en(step_en),
        .q(q), .phase(phase), .busy(busy), .loop_done(loop_done), .done(done),
        .loop_cnt(loop_cnt), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is the flat list of values for one loop, walked by index
    int m_us = 0, m_ue = 3, m_ds = 15, m_de = 12, m_loops = 0;
    int m_seq[$];
    int m_up_len = 0, m_idx = 0, m_q = 0, m_cnt = 0;
    bit m_busy = 0, m_ld = 0, m_done = 0, m_err = 0;

    function automatic void build_seq();
        m_seq.delete();
        for (int v = m_us; v <= m_ue; v++) m_seq.push_back(v);
        m_up_len = m_seq.size();
        for (int v = m_ds; v >= m_de; v--) m_seq.push_back(v);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_us = 0; m_ue = 3; m_ds = 15; m_de = 12; m_loops = 0;
            m_busy = 0; m_q = 0; m_cnt = 0; m_idx = 0;
            m_ld = 0; m_done = 0; m_err = 0;
        end else begin
            m_ld = 0; m_done = 0; m_err = 0;
            if (!m_busy) begin
                if (start) begin
                    build_seq();
                    m_idx = 0; m_q = m_seq[0]; m_cnt = 0; m_busy = 1;
                end else if (cfg_valid) begin
                    if (cfg_up_start <= cfg_up_end && cfg_dn_start >= cfg_dn_end) begin
                        m_us = int'(cfg_up_start); m_ue = int'(cfg_up_end);
                        m_ds = int'(cfg_dn_start); m_de = int'(cfg_dn_end);
                        m_loops = int'(cfg_loops);
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (stop) begin
                m_busy = 0;
            end else if (step_en) begin
                if (m_idx + 1 < m_seq.size()) begin
                    m_idx++;
                    m_q = m_seq[m_idx];
                end else begin
                    m_cnt = (m_cnt + 1) % 256;
                    m_ld = 1;
                    if (m_loops != 0 && m_cnt == m_loops) begin
                        m_busy = 0; m_done = 1;
                    end else begin
                        m_idx = 0; m_q = m_seq[0];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model q", int'(q), m_q);
            chk("model phase", int'(phase), !m_busy ? 0 : (m_idx < m_up_len ? 1 : 2));
            chk("model busy", int'(busy), int'(m_busy));
            chk("model loop_done", int'(loop_done), int'(m_ld));
            chk("model done", int'(done), int'(m_done));
            chk("model loop_cnt", int'(loop_cnt), m_cnt);
            chk("model cfg_err", int'(cfg_err), int'(m_err));
            chk("model cfg_ready", int'(cfg_ready), int'(!m_busy && !start));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    int exp1[10] = '{0, 1, 2, 3, 15, 14, 13, 12, 0, 1};
    int exp2[14] = '{2, 3, 4, 5, 9, 8, 7, 2, 3, 4, 5, 9, 8, 7};
    int pat5[4]  = '{1, 0, 0, 1};
    int exp5[4]  = '{2, 2, 2, 3};

    initial begin
        // 1: reset state, default pattern, infinite loops
        cyc(); cyc();
        chk("reset q", int'(q), 0);
        chk("reset phase", int'(phase), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset loop_cnt", int'(loop_cnt), 0);
        reset = 1'b0;
        chk_en = 1'b1;
        start = 1'b1;
        cyc();
        chk("t1 q0", int'(q), exp1[0]);
        chk("t1 phase0", int'(phase), 1);
        start = 1'b0; step_en = 1'b1;
        for (int i = 1; i < 10; i++) begin
            cyc();
            chk("t1 q", int'(q), exp1[i]);
            chk("t1 phase", int'(phase), (i < 4 || i >= 8) ? 1 : 2);
            chk("t1 done", int'(done), 0);
            if (i == 8) begin
                chk("t1 loop_done", int'(loop_done), 1);
                chk("t1 loop_cnt", int'(loop_cnt), 1);
            end
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0; step_en = 1'b0;
        chk("t1 stopped busy", int'(busy), 0);

        // 2: finite run of two loops with custom bounds
        cfg_up_start = 4'd2; cfg_up_end = 4'd5; cfg_dn_start = 4'd9; cfg_dn_end = 4'd7;
        cfg_loops = 8'd2; cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0; start = 1'b1;
        cyc();
        chk("t2 q0", int'(q), exp2[0]);
        start = 1'b0; step_en = 1'b1;
        for (int i = 1; i < 14; i++) begin
            cyc();
            chk("t2 q", int'(q), exp2[i]);
            if (i == 7) begin
                chk("t2 loop_done", int'(loop_done), 1);
                chk("t2 loop_cnt1", int'(loop_cnt), 1);
            end
        end
        cyc();
        chk("t2 end q", int'(q), 7);
        chk("t2 end busy", int'(busy), 0);
        chk("t2 end phase", int'(phase), 0);
        chk("t2 done", int'(done), 1);
        chk("t2 loop_cnt", int'(loop_cnt), 2);
        cyc();
        chk("t2 done single", int'(done), 0);
        chk("t2 q hold", int'(q), 7);
        step_en = 1'b0;

        // 3: rejected config leaves defaults in place
        reset = 1'b1; #2; reset = 1'b0;
        chk("t3 reset loop_cnt", int'(loop_cnt), 0);
        cfg_up_start = 4'd6; cfg_up_end = 4'd4; cfg_dn_start = 4'd15; cfg_dn_end = 4'd12;
        cfg_loops = 8'd1; cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        chk("t3 cfg_err", int'(cfg_err), 1);
        cyc();
        chk("t3 cfg_err pulse", int'(cfg_err), 0);
        start = 1'b1;
        cyc();
        start = 1'b0; step_en = 1'b1;
        chk("t3 q0", int'(q), 0);
        for (int i = 1; i < 6; i++) begin
            cyc();
            chk("t3 q", int'(q), exp1[i]);
        end

        // 4: stop beats step_en at q=14 in DOWN
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t4 q", int'(q), 14);
        chk("t4 phase", int'(phase), 0);
        chk("t4 done", int'(done), 0);
        chk("t4 loop_done", int'(loop_done), 0);
        cyc();
        chk("t4 idle step ignored", int'(q), 14);
        step_en = 1'b0;

        // 5: step_en gaps, then start+cfg_valid together
        start = 1'b1;
        cyc();
        start = 1'b0; step_en = 1'b1;
        cyc();
        chk("t5 q1", int'(q), 1);
        for (int k = 0; k < 4; k++) begin
            step_en = pat5[k][0];
            cyc();
            chk("t5 step q", int'(q), exp5[k]);
        end
        step_en = 1'b0; stop = 1'b1;
        cyc();
        stop = 1'b0;
        cfg_up_start = 4'd5; cfg_up_end = 4'd6; cfg_dn_start = 4'd8; cfg_dn_end = 4'd7;
        cfg_loops = 8'd1; cfg_valid = 1'b1; start = 1'b1;
        #1;
        chk("t5 cfg_ready low", int'(cfg_ready), 0);
        cyc();
        cfg_valid = 1'b0; start = 1'b0;
        chk("t5 old up_start", int'(q), 0);
        step_en = 1'b1;
        for (int i = 1; i < 7; i++) begin
            cyc();
            chk("t5 run q", int'(q), exp1[i]);
        end

        // 6: asynchronous reset mid-run at q=13
        #2; reset = 1'b1;
        #1;
        chk("t6 async q", int'(q), 0);
        chk("t6 async phase", int'(phase), 0);
        chk("t6 async busy", int'(busy), 0);
        #2; reset = 1'b0;
        step_en = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0; step_en = 1'b1;
        chk("t6 default q0", int'(q), 0);
        for (int i = 1; i < 10; i++) begin
            cyc();
            chk("t6 default q", int'(q), exp1[i]);
        end
        chk("t6 infinite busy", int'(busy), 1);
        step_en = 1'b0;
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
